bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder.sv | 135 +++++++++++++
 tb/tb_bus_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: wait-stated 16-bit RAM window on a simple CPU bus.
// One access at a time; the CPU must return CTRLBUS to 00 between accesses.
module bus_mem_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h8000,
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ADDRBUS,
    input  logic [1:0]  CTRLBUS,
    inout  wire  [15:0] DATABUS,
    output logic        BUSRDY,
    output logic        BUSERR
);

    localparam int          DEPTH   = 1 << ADDR_BITS;
    localparam logic [16:0] WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [16:0] WIN_HI  = WIN_LO + 17'(DEPTH);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0
                                    : 4'(WAIT_STATES - 1);

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_RSV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [1:0]           cmd_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic [15:0]          wdata_q;
    logic [15:0]          rdata_q;
    logic                 drive_q;

    logic [16:0]          addr_ext;
    logic                 hit;
    logic [ADDR_BITS-1:0] idx_in;
    logic [ADDR_BITS-1:0] raddr;

    logic [15:0]          mem [DEPTH];

    // Window decode in 17 bits so the top of the window never wraps.
    assign addr_ext = {1'b0, ADDRBUS};
    assign hit      = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    assign idx_in   = ADDR_BITS'(ADDRBUS - BASE_ADDR);

    // A zero-wait read goes straight from IDLE to RESP, so the RAM
    // must be addressed from the bus in IDLE and from the latch after.
    assign raddr = (state == IDLE) ? idx_in : idx_q;

    assign DATABUS = drive_q ? rdata_q : 16'hzzzz;

    // Access sequencer: accept, wait, respond, then hold until strobe drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            cmd_q   <= CMD_NONE;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            BUSRDY  <= 1'b0;
            BUSERR  <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            BUSRDY  <= 1'b0;
            BUSERR  <= 1'b0;
            drive_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        if (CTRLBUS == CMD_RD || CTRLBUS == CMD_WR) begin
                            cmd_q <= CTRLBUS;
                            idx_q <= idx_in;
                            if (CTRLBUS == CMD_WR) begin
                                wdata_q <= DATABUS;
                            end
                            if (WAIT_STATES == 0) begin
                                state   <= RESP;
                                BUSRDY  <= 1'b1;
                                drive_q <= (CTRLBUS == CMD_RD);
                            end else begin
                                state <= WAIT;
                                cnt   <= WS_LOAD;
                            end
                        end else if (CTRLBUS == CMD_RSV) begin
                            BUSERR <= 1'b1;
                            state  <= HOLD;
                        end
                    end
                end
                WAIT: begin
                    if (CTRLBUS != cmd_q) begin
                        BUSERR <= 1'b1;
                        cnt    <= 4'd0;
                        state  <= HOLD;
                    end else if (cnt == 4'd0) begin
                        state   <= RESP;
                        BUSRDY  <= 1'b1;
                        drive_q <= (cmd_q == CMD_RD);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (CTRLBUS == CMD_NONE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage: commit writes at the end of RESP; reads are registered.
    always_ff @(posedge clk) begin
        if (state == RESP && cmd_q == CMD_WR) begin
            mem[idx_q] <= wdata_q;
        end
        rdata_q <= mem[raddr];
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: two instances (0 and 2 waits),
// directed bus scenarios followed by randomised traffic.
module tb_bus_mem_responder;

    localparam logic [15:0] BASE  = 16'h8000;
    localparam int          ABITS = 8;
    localparam int          DEPTH = 256;
    localparam int          WS_A  = 0;
    localparam int          WS_B  = 2;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] RD  = 2'b01;
    localparam logic [1:0] WR  = 2'b10;
    localparam logic [1:0] RSV = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ab;
    logic [1:0]  cb0, cb1;
    logic        oe0, oe1;
    logic [15:0] wd;
    wire  [15:0] db0, db1;
    logic        rdy0, err0, rdy1, err1;

    assign db0 = oe0 ? wd : 16'hzzzz;
    assign db1 = oe1 ? wd : 16'hzzzz;

    bus_mem_responder #(
        .BASE_ADDR(BASE), .ADDR_BITS(ABITS), .WAIT_STATES(WS_A)
    ) u_a (
        .clk(clk), .reset(rst_n), .ADDRBUS(ab), .CTRLBUS(cb0),
        .DATABUS(db0), .BUSRDY(rdy0), .BUSERR(err0)
    );

    bus_mem_responder #(
        .BASE_ADDR(BASE), .ADDR_BITS(ABITS), .WAIT_STATES(WS_B)
    ) u_b (
        .clk(clk), .reset(rst_n), .ADDRBUS(ab), .CTRLBUS(cb1),
        .DATABUS(db1), .BUSRDY(rdy1), .BUSERR(err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          dut;
        int          cyc;
        bit          err;
        bit          rd;
        bit          known;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] mdl[int];
    int          tests = 0;
    int          fails = 0;

    function automatic bit in_win(input logic [15:0] a);
        return int'(a) >= int'(BASE) && int'(a) < int'(BASE) + DEPTH;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 0) ? WS_A : WS_B;
    endfunction

    function automatic void expect_ev(input int d, input int c, input bit e,
                                      input bit r, input bit k,
                                      input logic [15:0] v);
        exp_t x;
        x.dut = d; x.cyc = c; x.err = e; x.rd = r; x.known = k; x.data = v;
        sbq.push_back(x);
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic nxt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int d, input logic [1:0] cmd, input bit we);
        if (d == 0) begin
            cb0 = cmd; oe0 = we;
        end else begin
            cb1 = cmd; oe1 = we;
        end
    endtask

    // Complete bus access: strobe held through the response plus 'hold'.
    task automatic access(input int d, input logic [15:0] a,
                          input logic [1:0] cmd, input logic [15:0] v,
                          input int hold);
        int ws;
        int c;
        int key;
        ws  = ws_of(d);
        c   = cyc;
        key = d * 65536 + int'(a);
        ab  = a;
        wd  = v;
        drive(d, cmd, cmd == WR);
        if (!in_win(a) || cmd == NOP) begin
            nxt(1 + hold);
            drive(d, NOP, 1'b0);
            nxt(1);
            return;
        end
        if (cmd == RSV) begin
            expect_ev(d, c + 1, 1'b1, 1'b0, 1'b0, 16'h0);
            nxt(1 + hold);
        end else begin
            if (cmd == RD) begin
                expect_ev(d, c + 1 + ws, 1'b0, 1'b1, mdl.exists(key),
                          mdl.exists(key) ? mdl[key] : 16'h0);
            end else begin
                expect_ev(d, c + 1 + ws, 1'b0, 1'b0, 1'b0, 16'h0);
                mdl[key] = v;
            end
            nxt(ws + 1 + hold);
        end
        drive(d, NOP, 1'b0);
        nxt(2);
    endtask

    // Change the strobe k cycles into the wait phase (1 <= k <= waits).
    task automatic abort(input int d, input logic [15:0] a,
                         input logic [1:0] cmd, input logic [15:0] v,
                         input int k, input logic [1:0] nc);
        int c;
        c  = cyc;
        ab = a;
        wd = v;
        drive(d, cmd, cmd == WR);
        nxt(k);
        drive(d, nc, nc == WR);
        expect_ev(d, c + k + 1, 1'b1, 1'b0, 1'b0, 16'h0);
        nxt(1);
        drive(d, NOP, 1'b0);
        nxt(2);
    endtask

    // Pull reset k cycles after issuing a write (1 <= k <= waits + 1).
    task automatic reset_mid(input int d, input logic [15:0] a,
                             input logic [15:0] v, input int k);
        ab = a;
        wd = v;
        drive(d, WR, 1'b1);
        nxt(k);
        rst_n = 1'b0;
        drive(d, NOP, 1'b0);
        nxt(2);
        rst_n = 1'b1;
        nxt(1);
    endtask

    task automatic check_dut(input int d, input logic r, input logic e,
                             input logic [15:0] bus, input logic boe);
        bit   drv;
        bit   have;
        exp_t x;
        if (boe) drv = (bus !== wd);
        else     drv = !((bus === 16'hzzzz) || (bus === 16'h0000));
        have = 1'b0;
        if (sbq.size() > 0) begin
            have = (sbq[0].dut == d) && (sbq[0].cyc == cyc);
        end
        if (have) begin
            x = sbq.pop_front();
            cmp($sformatf("dut%0d rdy/err", d), {14'b0, r, e},
                {14'b0, !x.err, x.err});
            if (x.rd && x.known) begin
                cmp($sformatf("dut%0d rdata", d), bus, x.data);
            end else if (!x.rd) begin
                cmp($sformatf("dut%0d bus idle", d), {15'b0, drv}, 16'h0);
            end
        end else begin
            cmp($sformatf("dut%0d quiet", d), {13'b0, r, e, drv}, 16'h0);
        end
    endtask

    // Monitor: checks both instances every cycle against the scoreboard.
    initial begin
        exp_t s;
        forever begin
            @(negedge clk);
            #1;
            check_dut(0, rdy0, err0, db0, oe0);
            check_dut(1, rdy1, err1, db1, oe1);
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                s = sbq.pop_front();
                tests++;
                fails++;
                $display("FAIL dut%0d missing response due at cycle %0d",
                         s.dut, s.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        int          op;
        int          idx;
        int          r;
        logic [15:0] a;
        logic [1:0]  cmd;
        logic [1:0]  nc;

        ab = 16'h0; cb0 = NOP; cb1 = NOP; oe0 = 1'b0; oe1 = 1'b0;
        wd = 16'h0;
        nxt(3);
        rst_n = 1'b1;
        nxt(1);

        access(1, 16'h8005, WR, 16'hBEEF, 0);
        access(1, 16'h8005, RD, 16'h0, 0);
        access(0, 16'h8000, WR, 16'h1234, 0);
        access(0, 16'h8000, RD, 16'h0, 0);
        access(1, 16'h7FFF, RD, 16'h0, 0);
        access(1, 16'h8100, RD, 16'h0, 0);
        access(1, 16'h80FF, WR, 16'hA5A5, 0);
        access(1, 16'h80FF, RD, 16'h0, 0);
        access(1, 16'h8100, WR, 16'h5A5A, 0);
        access(1, 16'h80FF, RD, 16'h0, 0);
        access(1, 16'h8010, RSV, 16'h0, 4);
        access(1, 16'h8020, WR, 16'h0BAD, 0);
        abort(1, 16'h8020, WR, 16'h5555, 1, NOP);
        access(1, 16'h8020, RD, 16'h0, 0);
        access(1, 16'h8030, WR, 16'h3030, 0);
        reset_mid(1, 16'h8030, 16'hDEAD, 2);
        access(1, 16'h8030, RD, 16'h0, 3);
        access(0, 16'h8030, WR, 16'h4444, 0);
        reset_mid(0, 16'h8030, 16'h9999, 1);
        access(0, 16'h8030, RD, 16'h0, 0);

        for (int i = 0; i < 400; i++) begin
            d   = int'($urandom_range(1, 0));
            op  = int'($urandom_range(99, 0));
            if ($urandom_range(3, 0) == 0) idx = int'($urandom_range(255, 0));
            else                           idx = int'($urandom_range(15, 0));
            a   = 16'(int'(BASE) + idx);
            cmd = ($urandom_range(1, 0) == 1) ? RD : WR;
            wd  = 16'($urandom_range(65535, 1));
            if (op < 55) begin
                access(d, a, cmd, wd, int'($urandom_range(3, 0)));
            end else if (op < 65) begin
                r = int'($urandom_range(63, 0));
                if ($urandom_range(1, 0) == 1) a = 16'(int'(BASE) - 1 - r);
                else                           a = 16'(int'(BASE) + DEPTH + r);
                access(d, a, 2'($urandom_range(3, 1)), wd,
                       int'($urandom_range(2, 0)));
            end else if (op < 73) begin
                access(d, a, RSV, wd, int'($urandom_range(4, 0)));
            end else if (op < 93) begin
                if (ws_of(d) > 0) begin
                    nc = 2'($urandom_range(3, 0));
                    if (nc == cmd) nc = NOP;
                    abort(d, a, cmd, wd,
                          int'($urandom_range(ws_of(d), 1)), nc);
                end else begin
                    access(d, a, cmd, wd, 0);
                end
            end else begin
                reset_mid(d, a, wd, int'($urandom_range(ws_of(d) + 1, 1)));
            end
        end

        nxt(6);
        cmp("scoreboard drained", 16'(sbq.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
